// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one compare-and-subtract step per clock.
// Optional DIV_ZERO_DETECT_EN: B==0 short-circuits to Q=all ones, R=A, err=1.
module seq_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     qs, d, pr;
  logic [W-1:0]     qs_nxt, pr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;
`ifdef DIV_ZERO_DETECT_EN
  logic             zero_div;
`endif

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor when it fits, and shift the quotient bit into qs.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] p,
                                               input logic [W-1:0] q,
                                               input logic [W-1:0] dv);
    logic [W:0]   t;
    logic [W:0]   diff;
    logic         ge;
    logic [W-1:0] p_new;
    t     = {p, q[W-1]};
    diff  = t - {1'b0, dv};
    ge    = (t >= {1'b0, dv});
    p_new = ge ? diff[W-1:0] : t[W-1:0];
    return {p_new, q[W-2:0], ge};
  endfunction

  assign {pr_nxt, qs_nxt} = div_step(pr, qs, d);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    zero_div  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          zero_div  = (B == '0);
          state_nxt = zero_div ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (cnt == CNT_W'(W - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Working registers need no reset: they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      qs <= A;
      d  <= B;
      pr <= '0;
    end else if (state == RUN) begin
      qs <= qs_nxt;
      pr <= pr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= '0;
      else if (state == RUN)
        cnt <= cnt + CNT_W'(1);
      if (last) begin
        Q <= qs_nxt;
        R <= pr_nxt;
      end
`ifdef DIV_ZERO_DETECT_EN
      else if (zero_div) begin
        Q <= '1;
        R <= A;
      end
`endif
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (accept)
      err <= zero_div;
  end
`else
  assign err = 1'b0;
`endif

endmodule
